mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Multiply/divide unit in the EX stage; consumes the 4-bit mdu_op code and rs/rt operands produced by instruction decode.
- Owns the HI/LO registers.
- Executes MUL/MULT/MULTU over a fixed latency and DIV/DIVU with a 32-iteration radix-2 restoring divider.
- Returns MFHI/MFLO/MUL results to the EX result mux and raises a stall while an operation is in flight.

Parameters:
- MUL_CYCLES, 2, cycles spent in the MUL state (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  EX instruction valid (not a bubble)
- flush_i  in  1  exception/interrupt flush of EX; cancels the current op
- mdu_op_i  in  4  0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO; 10..15 treated as 0
- a_i  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b_i  in  32  rt operand (divisor / multiplier)
- result_o  out  32  value for rd (MFHI, MFLO, MUL)
- busy_o  out  1  pipeline stall request
- hi_o  out  32  current HI
- lo_o  out  32  current LO

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE, HI=LO=0, counter=0, all internal operand/product registers 0.
- Reset outputs: result_o=0, busy_o=0, hi_o=lo_o=0.
- States: IDLE, MUL, DIV, DONE.
- Issue definition: issue = IDLE & en_i & !flush_i & op in {1..5}.
- busy_o = issue | state==MUL | state==DIV (combinational); busy_o=0 in DONE.
- The EX stage holds its instruction while busy_o=1.

IDLE:
- On issue, latch op and the sign flags.
- MUL/MULT/MULTU: register the 64-bit product (signed for MUL/MULT, unsigned for MULTU), load counter=MUL_CYCLES, go to MUL.
- DIV/DIVU: latch |a|, |b| (raw values for DIVU), load counter=32, go to DIV.
- MTHI (MTLO) with en_i & !flush_i: HI (LO) <= a_i at the edge; no stall.
- MFHI/MFLO with en_i: result_o = HI/LO combinationally, 0-cycle, no stall.

MUL:
- Decrement counter each cycle; go to DONE when the counter reaches 1.
- Total busy cycles = MUL_CYCLES+1, including the issue cycle.

DIV:
- One restoring step per cycle: shift the remainder/quotient pair left by 1, trial-subtract the divisor, set quotient bit if the result is non-negative.
- Exactly 32 cycles; DONE is reached 33 cycles after issue.

DONE (exactly one cycle):
- en_i and mdu_op_i are ignored; the held instruction is considered complete and the pipeline advances at this edge.
- At the edge, per op:
  - MULT/MULTU: HI=prod[63:32], LO=prod[31:0].
  - MUL: HI/LO unchanged; result_o = prod[31:0] during DONE.
  - DIV: LO = quotient, negated if the operand signs differ; HI = remainder with the sign of the dividend.
  - DIVU: LO = quotient, HI = remainder.
- Next state IDLE.
- result_o is 0 in DONE for every op except MUL.

Divide special cases:
- Divide-by-zero (b==0 latched at issue), DIV and DIVU: LO=0xFFFFFFFF, HI=a (raw dividend). Latency unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, with no special-casing.

result_o is 0 in every case not covered above.

flush_i:
- Highest priority. In MUL/DIV/DONE: next state IDLE, HI/LO not updated, busy_o drops in the next cycle.
- In IDLE: suppresses issue and MTHI/MTLO writes.

hi_o/lo_o track the registers directly; updates appear in the cycle after the writing edge.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy_o high 3 cycles (MUL_CYCLES=2); after DONE HI=0xFFFFFFFF, LO=0xFFFFFFFA. Then MFHI -> result_o=0xFFFFFFFF with no stall.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MUL a=7, b=-3 -> result_o=0xFFFFFFEB in DONE, HI/LO unchanged.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy_o high exactly 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0xA5A5A5A5, then MTLO a=0x5A5A5A5A on the next cycle -> hi_o/lo_o updated one cycle after each write, busy_o never high. MFLO -> 0x5A5A5A5A.
- Flush/reset abort: DIV issued, flush_i at iteration 10 -> IDLE next cycle, HI/LO keep prior values. Then an immediate MULT issues normally. rst_n low mid-DIV -> busy_o=0 and HI=LO=0 asynchronously.

Source files
------------

// File: rtl/mdu_iter.sv
// Multiply/divide unit for the EX stage: owns HI/LO and runs MUL/MULT/MULTU/DIV/DIVU.
// Latency: mul ops MUL_CYCLES+1 busy cycles, div ops 33 busy cycles, then one DONE cycle; MF*/MT* take 0 cycles.
// Backpressure: busy_o stalls EX from the issue cycle until DONE; flush_i aborts at once without touching HI/LO.
module mdu_iter #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [3:0]  mdu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_DIV   = 4'd1;
    localparam logic [3:0] OP_DIVU  = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MULT  = 4'd4;
    localparam logic [3:0] OP_MULTU = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [5:0]  cnt;
    logic [63:0] prod;
    logic [31:0] divisor;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] dividend_raw;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        is_mul_op;
    logic        is_div_op;
    logic        issue;
    logic        mul_signed;
    logic        div_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod_next;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_sh;
    logic        sub_ok;
    logic [31:0] rem_sub;
    logic [31:0] done_lo;
    logic [31:0] done_hi;

    // Issue decode, operand conditioning, one restoring-divide step and the final sign fix-up.
    always_comb begin
        is_mul_op  = (mdu_op_i == OP_MUL) || (mdu_op_i == OP_MULT) || (mdu_op_i == OP_MULTU);
        is_div_op  = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
        issue      = (state == S_IDLE) && en_i && !flush_i && (is_mul_op || is_div_op);
        // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply equal the signed product.
        mul_signed = (mdu_op_i != OP_MULTU);
        a_ext      = {{32{mul_signed & a_i[31]}}, a_i};
        b_ext      = {{32{mul_signed & b_i[31]}}, b_i};
        prod_next  = a_ext * b_ext;
        div_signed = (mdu_op_i == OP_DIV);
        a_abs      = (div_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
        b_abs      = (div_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
        // Shift the remainder/quotient pair left; the trial difference fits 32 bits whenever it is non-negative.
        rem_sh     = {rem, quot[31]};
        sub_ok     = (rem_sh >= {1'b0, divisor});
        rem_sub    = rem_sh[31:0] - divisor;
        if (div_zero) begin
            done_lo = 32'hFFFF_FFFF;
            done_hi = dividend_raw;
        end else begin
            done_lo = q_neg ? (32'd0 - quot) : quot;
            done_hi = r_neg ? (32'd0 - rem) : rem;
        end
    end

    // Stall request and the rd value returned to the EX result mux.
    always_comb begin
        busy_o   = issue || (state == S_MUL) || (state == S_DIV);
        result_o = 32'd0;
        if (state == S_IDLE && en_i && mdu_op_i == OP_MFHI) begin
            result_o = hi;
        end else if (state == S_IDLE && en_i && mdu_op_i == OP_MFLO) begin
            result_o = lo;
        end else if (state == S_DONE && op_q == OP_MUL) begin
            result_o = prod[31:0];
        end
    end

    // Sequencer and datapath registers: operand capture at issue, countdown in MUL, one divide step per DIV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= 4'd0;
            cnt          <= 6'd0;
            prod         <= 64'd0;
            divisor      <= 32'd0;
            rem          <= 32'd0;
            quot         <= 32'd0;
            dividend_raw <= 32'd0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            div_zero     <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q <= mdu_op_i;
                        if (is_mul_op) begin
                            prod  <= prod_next;
                            cnt   <= 6'(MUL_CYCLES);
                            state <= S_MUL;
                        end else begin
                            divisor      <= b_abs;
                            quot         <= a_abs;
                            rem          <= 32'd0;
                            dividend_raw <= a_i;
                            q_neg        <= div_signed & (a_i[31] ^ b_i[31]);
                            r_neg        <= div_signed & a_i[31];
                            div_zero     <= (b_i == 32'd0);
                            cnt          <= 6'd32;
                            state        <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) state <= S_DONE;
                end
                S_DIV: begin
                    cnt  <= cnt - 6'd1;
                    rem  <= sub_ok ? rem_sub : rem_sh[31:0];
                    quot <= {quot[30:0], sub_ok};
                    if (cnt == 6'd1) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // HI/LO architectural state: MTHI/MTLO writes in IDLE, result commit at the DONE edge, nothing on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (!flush_i) begin
            if (state == S_IDLE && en_i) begin
                if (mdu_op_i == OP_MTHI) hi <= a_i;
                if (mdu_op_i == OP_MTLO) lo <= a_i;
            end else if (state == S_DONE) begin
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else if (op_q == OP_DIV || op_q == OP_DIVU) begin
                    hi <= done_hi;
                    lo <= done_lo;
                end
            end
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule
